// File: rtl/time_of_day_keeper.sv
// ---------------------------------------------------------------------------
// time_of_day_keeper
//
// Purpose:
//   Keeps time of day (hours/minutes, binary 24h internally) advanced by a
//   one-minute tick, holds an alarm time, and raises alarm_active when a
//   tick-driven advance lands on the alarm time. A three-mode FSM
//   (RUN / SET_TIME / SET_ALARM), stepped by mode_btn, selects what the
//   inc_hr / inc_min buttons edit and what the display shows.
//
// Optional feature (compile-time macro):
//   TWELVE_HOUR_EN - hour digits show 12,1..11 and pm = (hour >= 12) for both
//                    time and alarm displays. Registers and the alarm compare
//                    stay 24h. When undefined, hours show 00..23 and pm = 0.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous reset, active-low
//   min_tick       in   one-cycle pulse per elapsed minute
//   mode_btn       in   one-cycle pulse, advances the mode FSM
//   inc_hr         in   one-cycle pulse, hour +1 in the set modes
//   inc_min        in   one-cycle pulse, minute +1 in the set modes
//   alarm_en       in   level, alarm armed when 1
//   alarm_dismiss  in   one-cycle pulse, clears alarm_active
//   hr_tens/hr_ones/min_tens/min_ones  out  BCD digits of the displayed value
//   pm             out  PM indicator (12h build only, else 0)
//   mode           out  FSM state: 00 RUN, 01 SET_TIME, 10 SET_ALARM
//   sec_clr        out  one-cycle pulse clearing the upstream seconds count
//   alarm_active   out  alarm ringing
//
// Handshake: all button inputs are single-cycle pulses sampled on the rising
// clock edge; there is no back-pressure, every pulse is consumed the cycle
// it is seen.
// ---------------------------------------------------------------------------
module time_of_day_keeper #(
  parameter int RESET_HOUR = 0,
  parameter int RESET_MIN  = 0,
  parameter int ALARM_HOUR = 7,
  parameter int ALARM_MIN  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       min_tick,
  input  logic       mode_btn,
  input  logic       inc_hr,
  input  logic       inc_min,
  input  logic       alarm_en,
  input  logic       alarm_dismiss,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic       pm,
  output logic [1:0] mode,
  output logic       sec_clr,
  output logic       alarm_active
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    SET_TIME  = 2'b01,
    SET_ALARM = 2'b10
  } mode_t;

  mode_t      state;
  logic [4:0] hr;
  logic [5:0] min;
  logic [4:0] al_hr;
  logic [5:0] al_min;
  // Registered "a tick just landed on the alarm time" flag; it sets
  // alarm_active one cycle after the tick edge.
  logic       tick_hit;

  // Wrapping increments.
  logic [4:0] hr_nx;
  logic [5:0] min_nx;
  logic [4:0] al_hr_nx;
  logic [5:0] al_min_nx;
  // Time after a tick-driven advance (minute carry into hour).
  logic [4:0] tick_hr;
  logic [5:0] tick_min;

  assign hr_nx     = (hr == 5'd23)     ? 5'd0 : hr + 5'd1;
  assign min_nx    = (min == 6'd59)    ? 6'd0 : min + 6'd1;
  assign al_hr_nx  = (al_hr == 5'd23)  ? 5'd0 : al_hr + 5'd1;
  assign al_min_nx = (al_min == 6'd59) ? 6'd0 : al_min + 6'd1;
  assign tick_min  = min_nx;
  assign tick_hr   = (min == 6'd59) ? hr_nx : hr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      hr           <= 5'(RESET_HOUR);
      min          <= 6'(RESET_MIN);
      al_hr        <= 5'(ALARM_HOUR);
      al_min       <= 6'(ALARM_MIN);
      sec_clr      <= 1'b0;
      tick_hit     <= 1'b0;
      alarm_active <= 1'b0;
    end else begin
      sec_clr  <= 1'b0;
      tick_hit <= 1'b0;

      case (state)
        RUN: begin
          if (mode_btn) state <= SET_TIME;
          if (min_tick) begin
            min      <= tick_min;
            hr       <= tick_hr;
            tick_hit <= alarm_en && (tick_hr == al_hr) && (tick_min == al_min);
          end
        end
        SET_TIME: begin
          // Clock paused: min_tick ignored, no carry from minute into hour.
          if (mode_btn) begin
            state   <= SET_ALARM;
            sec_clr <= 1'b1;
          end
          if (inc_min) min <= min_nx;
          if (inc_hr)  hr  <= hr_nx;
        end
        SET_ALARM: begin
          // Time keeps running here, but only RUN can trigger the alarm.
          if (mode_btn) state <= RUN;
          if (min_tick) begin
            min <= tick_min;
            hr  <= tick_hr;
          end
          if (inc_min) al_min <= al_min_nx;
          if (inc_hr)  al_hr  <= al_hr_nx;
        end
        default: state <= RUN;
      endcase

      // Disarm beats everything; a fresh trigger beats a dismiss.
      if (!alarm_en)          alarm_active <= 1'b0;
      else if (tick_hit)      alarm_active <= 1'b1;
      else if (alarm_dismiss) alarm_active <= 1'b0;
    end
  end

  assign mode = state;

  // Binary (0..59) to two BCD digits.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    if (v >= 6'd50)      begin tens = 4'd5; rem = v - 6'd50; end
    else if (v >= 6'd40) begin tens = 4'd4; rem = v - 6'd40; end
    else if (v >= 6'd30) begin tens = 4'd3; rem = v - 6'd30; end
    else if (v >= 6'd20) begin tens = 4'd2; rem = v - 6'd20; end
    else if (v >= 6'd10) begin tens = 4'd1; rem = v - 6'd10; end
    else                 begin tens = 4'd0; rem = v;         end
    return {tens, rem[3:0]};
  endfunction

  logic [4:0] disp_hr;
  logic [5:0] disp_min;
  logic [4:0] shown_hr;

  assign disp_hr  = (state == SET_ALARM) ? al_hr  : hr;
  assign disp_min = (state == SET_ALARM) ? al_min : min;

`ifdef TWELVE_HOUR_EN
  always_comb begin
    shown_hr = disp_hr;
    if (disp_hr == 5'd0)       shown_hr = 5'd12;
    else if (disp_hr > 5'd12)  shown_hr = disp_hr - 5'd12;
  end
  assign pm = (disp_hr >= 5'd12);
`else
  assign shown_hr = disp_hr;
  assign pm       = 1'b0;
`endif

  assign {hr_tens, hr_ones}   = to_bcd({1'b0, shown_hr});
  assign {min_tens, min_ones} = to_bcd(disp_min);

endmodule
